cp_insert: RTL and testbench
============================

// Module: cp_insert
// PURPOSE
//  Transmit-side OFDM cyclic-prefix inserter. Generates the stream that the timing/CFO estimator consumes.
//  Accepts N time-domain complex samples per symbol (IFFT output) over a valid/ready handshake.
//  Emits L CP samples (copies of indices N-L..N-1) and then the N body samples, i.e. N+L samples per symbol.
//  Output is continuous and has no backpressure, because the receiver chain has no ready input.
//  Ping-pong buffering lets one symbol be read out while the next is being written.
// PARAMETERS
//  N          256  samples per OFDM symbol (power of 2)
//  L          16   cyclic-prefix length (1..N-1)
//  INT_BITS   1    integer bits of each I/Q sample (signed)
//  FRAC_BITS  15   fraction bits of each I/Q sample
// PORTS
//  clk        in   1                    single clock, rising edge
//  rst        in   1                    asynchronous, active-high reset
//  in_valid   in   1                    in_re/in_img carry a sample
//  in_ready   out  1                    block can accept a sample this cycle
//  in_re      in   INT_BITS+FRAC_BITS   signed I input sample
//  in_img     in   INT_BITS+FRAC_BITS   signed Q input sample
//  out_valid  out  1                    out_re/out_img carry a transmit sample
//  out_re     out  INT_BITS+FRAC_BITS   signed I output sample
//  out_img    out  INT_BITS+FRAC_BITS   signed Q output sample
//  out_sos    out  1                    first CP sample of a symbol (start of symbol)
//  out_eos    out  1                    last body sample of a symbol (end of symbol)
//  sym_cnt    out  16                   count of symbols fully emitted; wraps modulo 2^16
// BEHAVIOUR
//  Reset: all outputs are 0 except in_ready. in_ready=1. Both banks are empty. wr_bank=0, wr_ptr=0. Read FSM is in IDLE.
//  Handshake: a sample is accepted on a rising edge with in_valid&&in_ready.
//   - in_valid while in_ready=0 is ignored; the sample is dropped and the source must hold it.
//  Write side: the accepted sample goes to bank[wr_bank][wr_ptr], then wr_ptr++.
//   - At wr_ptr==N-1 the accept sets full[wr_bank], resets wr_ptr to 0 and toggles wr_bank.
//   - in_ready = !full[wr_bank], combinational from registers.
//  Read FSM states: IDLE, CP, BODY. rd_bank and rd_ptr are registers.
//   - IDLE -> CP when full[rd_bank]; rd_ptr <= N-L.
//   - CP: rd_ptr++ each cycle. After reading index N-1 -> BODY with rd_ptr <= 0.
//   - BODY: rd_ptr++ each cycle. After reading index N-1: clear full[rd_bank], toggle rd_bank, sym_cnt++.
//     Then go to CP if full[other bank], otherwise IDLE.
//  No idle gap between back-to-back symbols when the writer keeps up.
//  Read data is registered, so outputs appear 1 cycle after the address is issued.
//  Latency: Nth sample accepted at edge k -> first CP sample on outputs after edge k+2.
//  out_valid stays high for exactly N+L consecutive cycles per symbol.
//  out_sos is high with the first CP sample; out_eos is high with body index N-1.
//  When out_valid=0, out_re/out_img hold 0.
//  Simultaneous release and fill: if the reader clears full[b] on the same edge the writer tries to fill bank b,
//   the writer is blocked anyway because in_ready was 0. No write may hit a bank while full=1.
//   Clear and set on different banks in the same edge both take effect.
//  Throughput: the writer may run at 1 sample/cycle. It stalls (in_ready=0) only when both banks are full.
//  Reset mid-operation: a partial input symbol is discarded. An output symbol in flight is truncated and out_valid drops to 0.
//   sym_cnt returns to 0.
//  No arithmetic on samples: bit-exact copy, no rounding or saturation.
// STRUCTURE
//  Shared package data_type.svh supplies:
//   - r_t, the sample type shared with the receiver;
//   - N_FFT=256 and CP_LEN=16 constants, used here and by the estimator top counter (2N+L).
//  Sub-module sample_bank: simple dual-port RAM, 2*N x 2*(INT_BITS+FRAC_BITS).
//   - addr = {bank, ptr}; synchronous write; registered read.
//  This module contains the write counter, the read FSM, the full[1:0] flags and the output flags.
// TESTING
//  1) Single symbol, in[i]=(i, -i), i=0..255 -> 272 outputs:
//     (240,-240)..(255,-255) then (0,0)..(255,-255); sos on #0, eos on #271, sym_cnt=1.
//  2) Latency: last input accepted at edge k -> out_valid first high after edge k+2.
//  3) Continuous input, 4 symbols at 1 sample/cycle -> out_valid high for 1088 contiguous cycles;
//     in_ready drops periodically while both banks are full; no sample lost or duplicated.
//  4) in_valid held high while in_ready=0 -> no extra writes; the output sequence equals the accepted samples only.
//  5) Reset asserted at output cycle 100 of symbol 2 -> next cycle: out_valid=0, sym_cnt=0, in_ready=1;
//     a fresh symbol then emits correctly.
//  6) Extremes: samples 16'h8000 and 16'h7FFF pass bit-exact; random gaps in in_valid -> the output matches a
//     reference model (CP = last L samples + body).

Source files
------------

// File: rtl/cp_insert_pkg.sv
// Shared sample type, symbol geometry and read-FSM encoding for the cyclic-prefix inserter.
package cp_insert_pkg;
    localparam int N_FFT     = 256;
    localparam int CP_LEN    = 16;
    localparam int INT_BITS  = 1;
    localparam int FRAC_BITS = 15;
    localparam int SW        = INT_BITS + FRAC_BITS;

    typedef logic signed [SW-1:0] r_t;

    typedef struct packed {
        r_t re;
        r_t im;
    } iq_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CP   = 2'd1,
        ST_BODY = 2'd2
    } rd_state_t;
endpackage

// File: rtl/cp_insert_if.sv
// Sample-in handshake and transmit-stream bundle of the cyclic-prefix inserter.
interface cp_insert_if;
    import cp_insert_pkg::*;

    logic        in_valid;
    logic        in_ready;
    r_t          in_re;
    r_t          in_img;
    logic        out_valid;
    r_t          out_re;
    r_t          out_img;
    logic        out_sos;
    logic        out_eos;
    logic [15:0] sym_cnt;

    modport slave (
        input  in_valid, in_re, in_img,
        output in_ready, out_valid, out_re, out_img, out_sos, out_eos, sym_cnt
    );

    modport master (
        output in_valid, in_re, in_img,
        input  in_ready, out_valid, out_re, out_img, out_sos, out_eos, sym_cnt
    );
endinterface

// File: rtl/cp_insert_bank.sv
// Simple dual-port sample RAM, address {bank, ptr}.
// Latency: synchronous write, read data registered one cycle after the address.
module cp_insert_bank #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdat,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdat
);
    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdat;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
        r_rdat <= r_mem[i_raddr];
    end

    assign o_rdat = r_rdat;
endmodule

// File: rtl/cp_insert.sv
// Cyclic-prefix inserter: ping-pong buffers N-sample symbols and emits the last L samples before the body.
// Latency: first CP sample appears two cycles after the symbol's last input sample is accepted.
// Backpressure: in_ready falls only while both banks are full; the output stream never stalls.
module cp_insert
    import cp_insert_pkg::*;
#(
    parameter int N = N_FFT,
    parameter int L = CP_LEN
) (
    input  logic       clk,
    input  logic       rst,
    cp_insert_if.slave io
);
    localparam int PW = $clog2(N);

    logic [1:0]    r_full;
    logic [1:0]    w_full_nxt;
    logic          r_wr_bank;
    logic [PW-1:0] r_wr_ptr;
    logic          w_accept;
    logic          w_wr_last;
    rd_state_t     r_state;
    rd_state_t     w_state_nxt;
    logic          r_rd_bank;
    logic          w_rd_bank_nxt;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] w_rd_ptr_nxt;
    logic [15:0]   r_sym_cnt;
    logic [15:0]   w_sym_cnt_nxt;
    logic          w_release;
    logic          r_out_vld;
    logic          r_sos;
    logic          r_eos;
    iq_t           w_rd_dat;

    assign io.in_ready = ~r_full[r_wr_bank];
    assign w_accept    = io.in_valid & ~r_full[r_wr_bank];
    assign w_wr_last   = (r_wr_ptr == PW'(N-1));

    cp_insert_bank #(
        .AW (PW + 1),
        .DW ($bits(iq_t))
    ) u_bank (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr ({r_wr_bank, r_wr_ptr}),
        .i_wdat  ({io.in_re, io.in_img}),
        .i_raddr ({r_rd_bank, r_rd_ptr}),
        .o_rdat  (w_rd_dat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_bank <= 1'b0;
            r_wr_ptr  <= '0;
        end else if (w_accept) begin
            r_wr_ptr <= w_wr_last ? '0 : r_wr_ptr + 1'b1;
            if (w_wr_last) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    // Continuing straight into the other bank is what keeps back-to-back symbols gap-free.
    always_comb begin
        w_state_nxt   = r_state;
        w_rd_ptr_nxt  = r_rd_ptr;
        w_rd_bank_nxt = r_rd_bank;
        w_sym_cnt_nxt = r_sym_cnt;
        w_release     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_state_nxt  = ST_CP;
                    w_rd_ptr_nxt = PW'(N-L);
                end
            end
            ST_CP: begin
                if (r_rd_ptr == PW'(N-1)) begin
                    w_state_nxt  = ST_BODY;
                    w_rd_ptr_nxt = '0;
                end else begin
                    w_rd_ptr_nxt = r_rd_ptr + 1'b1;
                end
            end
            ST_BODY: begin
                if (r_rd_ptr == PW'(N-1)) begin
                    w_release     = 1'b1;
                    w_rd_bank_nxt = ~r_rd_bank;
                    w_sym_cnt_nxt = r_sym_cnt + 16'd1;
                    if (r_full[~r_rd_bank]) begin
                        w_state_nxt  = ST_CP;
                        w_rd_ptr_nxt = PW'(N-L);
                    end else begin
                        w_state_nxt  = ST_IDLE;
                    end
                end else begin
                    w_rd_ptr_nxt = r_rd_ptr + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A released bank is never the one being filled: the writer is held off while it is full.
    always_comb begin
        w_full_nxt = r_full;
        if (w_release) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
        if (w_accept && w_wr_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rd_bank <= 1'b0;
            r_rd_ptr  <= '0;
            r_sym_cnt <= '0;
            r_full    <= '0;
            r_out_vld <= 1'b0;
            r_sos     <= 1'b0;
            r_eos     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_bank <= w_rd_bank_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_sym_cnt <= w_sym_cnt_nxt;
            r_full    <= w_full_nxt;
            r_out_vld <= (r_state != ST_IDLE);
            r_sos     <= (r_state == ST_CP)   && (r_rd_ptr == PW'(N-L));
            r_eos     <= (r_state == ST_BODY) && (r_rd_ptr == PW'(N-1));
        end
    end

    assign io.out_valid = r_out_vld;
    assign io.out_re    = r_out_vld ? w_rd_dat.re : '0;
    assign io.out_img   = r_out_vld ? w_rd_dat.im : '0;
    assign io.out_sos   = r_sos;
    assign io.out_eos   = r_eos;
    assign io.sym_cnt   = r_sym_cnt;
endmodule

// File: tb/tb_cp_insert.sv
// Scoreboard bench for cp_insert: a symbol-level model queues the expected stream, a monitor pops and compares.
module tb_cp_insert;
    import cp_insert_pkg::*;

    localparam int N = N_FFT;
    localparam int L = CP_LEN;

    typedef struct packed {
        r_t   re;
        r_t   im;
        logic sos;
        logic eos;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    cp_insert_if ifc ();

    cp_insert dut (
        .clk (clk),
        .rst (rst),
        .io  (ifc.slave)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: a symbol becomes visible only once all N samples are accepted,
    // and is then transmitted as its last L samples followed by all N samples.
    r_t          sym_re[$];
    r_t          sym_im[$];
    exp_t        exp_q[$];
    int          exp_sym       = 0;
    int unsigned sym_done_edge = 0;

    task automatic model_accept(input r_t re, input r_t im);
        exp_t e;
        sym_re.push_back(re);
        sym_im.push_back(im);
        if (sym_re.size() == N) begin
            sym_done_edge = cyc + 1;
            for (int i = N - L; i < N; i++) begin
                e.re = sym_re[i]; e.im = sym_im[i]; e.sos = (i == N - L); e.eos = 1'b0;
                exp_q.push_back(e);
            end
            for (int i = 0; i < N; i++) begin
                e.re = sym_re[i]; e.im = sym_im[i]; e.sos = 1'b0; e.eos = (i == N - 1);
                exp_q.push_back(e);
            end
            sym_re.delete();
            sym_im.delete();
        end
    endtask

    // Monitor
    int          pos       = 0;
    int          sos_seen  = 0;
    int          run       = 0;
    int          last_run  = 0;
    int          stall_cyc = 0;
    int unsigned last_sos_cyc = 0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            run = 0;
        end else begin
            if (ifc.in_valid && !ifc.in_ready) stall_cyc++;
            if (ifc.out_valid) begin
                run++;
                if (ifc.out_sos) begin
                    pos = 0;
                    sos_seen++;
                    last_sos_cyc = cyc;
                end else begin
                    pos++;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got re=%0h im=%0h with nothing expected", ifc.out_re, ifc.out_img);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_sample{re,im,sos,eos}", {ifc.out_re, ifc.out_img, ifc.out_sos, ifc.out_eos},
                        {e.re, e.im, e.sos, e.eos});
                    if (e.eos) begin
                        exp_sym++;
                        chk("sym_cnt_at_eos", ifc.sym_cnt, exp_sym[15:0]);
                    end
                end
            end else begin
                if (run != 0) last_run = run;
                run = 0;
                chk("idle_outputs_zero", {ifc.out_re, ifc.out_img, ifc.out_sos, ifc.out_eos}, 64'd0);
            end
        end
    end

    // Driver
    bit abort = 1'b0;

    task automatic send(input r_t re, input r_t im, input int gap);
        int w;
        if (abort) return;
        for (int g = 0; g < gap; g++) begin
            ifc.in_valid = 1'b0;
            ifc.in_re    = r_t'($urandom_range(0, 65535));
            ifc.in_img   = r_t'($urandom_range(0, 65535));
            @(negedge clk);
            if (abort) return;
        end
        ifc.in_valid = 1'b1;
        ifc.in_re    = re;
        ifc.in_img   = im;
        w = 0;
        while (!ifc.in_ready) begin
            @(negedge clk);
            w++;
            if (abort) begin
                ifc.in_valid = 1'b0;
                return;
            end
            if (w > 4 * (N + L)) begin
                checks++;
                failures++;
                $display("FAIL in_ready_timeout: in_ready low for %0d cycles, limit %0d", w, 4 * (N + L));
                abort = 1'b1;
                ifc.in_valid = 1'b0;
                return;
            end
        end
        model_accept(re, im);
        @(negedge clk);
        ifc.in_valid = 1'b0;
    endtask

    // kind 0: ramp (i,-i); kind 1: random; kind 2: random with full-scale extremes planted
    task automatic send_sym(input int kind, input int max_gap);
        r_t re;
        r_t im;
        for (int i = 0; i < N; i++) begin
            if (kind == 0) begin
                re = r_t'(i);
                im = r_t'(-i);
            end else begin
                re = r_t'($urandom_range(0, 65535));
                im = r_t'($urandom_range(0, 65535));
            end
            if (kind == 2) begin
                if (i == 0)     begin re = r_t'(16'h7FFF); im = r_t'(16'h8000); end
                if (i == N / 2) begin re = r_t'(16'h8000); im = r_t'(16'h8000); end
                if (i == N - L) begin re = r_t'(16'h7FFF); im = r_t'(16'h7FFF); end
                if (i == N - 1) begin re = r_t'(16'h8000); im = r_t'(16'h7FFF); end
            end
            send(re, im, (max_gap == 0) ? 0 : $urandom_range(0, max_gap));
        end
    endtask

    task automatic wait_drain(input string name);
        int w;
        w = 0;
        @(posedge clk); #1;
        while ((exp_q.size() != 0 || ifc.out_valid) && w < 5000) begin
            @(posedge clk); #1;
            w++;
        end
        checks++;
        if (exp_q.size() != 0 || ifc.out_valid) begin
            failures++;
            $display("FAIL %s_drain: %0d samples still outstanding, required 0", name, exp_q.size());
        end
        @(negedge clk); #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin : main
        int wt;
        ifc.in_valid = 1'b0;
        ifc.in_re    = '0;
        ifc.in_img   = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state{vld,re,im,sos,eos,cnt,rdy}",
            {ifc.out_valid, ifc.out_re, ifc.out_img, ifc.out_sos, ifc.out_eos, ifc.sym_cnt, ifc.in_ready},
            64'd1);
        #2 rst = 1'b0;

        // single ramp symbol, latency and count
        @(negedge clk);
        send_sym(0, 0);
        wait_drain("t1");
        chk("t1_first_output_edge", last_sos_cyc, sym_done_edge + 2);
        chk("t1_sym_cnt", ifc.sym_cnt, 16'd1);
        chk("t1_sos_count", sos_seen, 1);

        // four symbols at full rate: stalls occur, output stays contiguous
        last_run  = 0;
        stall_cyc = 0;
        @(negedge clk);
        for (int s = 0; s < 4; s++) send_sym(1, 0);
        wait_drain("t3");
        chk("t3_contiguous_valid_run", last_run, 4 * (N + L));
        chk("t3_in_ready_stalled", (stall_cyc > 0), 1);
        chk("t3_sym_cnt", ifc.sym_cnt, 16'd5);

        // reset in the middle of the second symbol's output
        @(negedge clk);
        sos_seen = 0;
        abort    = 1'b0;
        fork
            begin
                for (int s = 0; s < 4; s++) send_sym(1, 0);
            end
            begin
                wt = 0;
                while (!(sos_seen == 2 && pos >= 100) && wt < 5000) begin
                    @(posedge clk); #1;
                    wt++;
                end
                chk("t5_reached_sym2_cycle100", (sos_seen == 2 && pos >= 100), 1);
                abort = 1'b1;
                rst   = 1'b1;
                exp_q.delete();
                sym_re.delete();
                sym_im.delete();
                exp_sym = 0;
                @(negedge clk); #1;
                chk("t5_after_reset{vld,sos,eos,cnt,rdy}",
                    {ifc.out_valid, ifc.out_sos, ifc.out_eos, ifc.sym_cnt, ifc.in_ready}, 64'd1);
                @(posedge clk); #1;
                rst = 1'b0;
            end
        join
        abort        = 1'b0;
        ifc.in_valid = 1'b0;
        @(negedge clk);
        chk("t5_idle_after_reset{vld,cnt,rdy}", {ifc.out_valid, ifc.sym_cnt, ifc.in_ready}, 64'd1);
        send_sym(1, 2);
        wait_drain("t5");
        chk("t5_fresh_sym_cnt", ifc.sym_cnt, 16'd1);

        // full-scale samples and random input gaps
        @(negedge clk);
        send_sym(2, 3);
        send_sym(2, 0);
        send_sym(2, 5);
        wait_drain("t6");
        chk("t6_sym_cnt", ifc.sym_cnt, 16'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
